// File: rtl/rc4_pkg.sv
// Shared types and helpers for the RC4 key-scheduling engine.
package rc4_pkg;

  localparam int SBOX_DEPTH    = 256;
  localparam int BYTE_W        = 8;
  localparam int MAX_KEY_BYTES = 32;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FILL,
    ST_RD_I,
    ST_WAIT_I,
    ST_CALC_J,
    ST_RD_J,
    ST_WAIT_J,
    ST_WR_J,
    ST_WR_I,
    ST_NEXT,
    ST_DONE
  } state_t;

  // Key byte k of an n_bytes-long key; byte 0 sits in the most significant position.
  function automatic logic [BYTE_W-1:0] key_byte(
    input logic [MAX_KEY_BYTES*BYTE_W-1:0] key_vec,
    input int unsigned                     n_bytes,
    input logic [4:0]                      k
  );
    int unsigned shamt;
    shamt = BYTE_W * (n_bytes - 1 - {27'd0, k});
    return BYTE_W'(key_vec >> shamt);
  endfunction

endpackage

// File: rtl/rc4_rd_wait.sv
// Read-latency down-counter: loaded while a read address is presented, it
// flags the cycle on which the RAM read data becomes valid.
module rc4_rd_wait #(
  parameter int MEM_RD_LAT = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic last
);

  localparam logic [2:0] LOAD_VAL = 3'(MEM_RD_LAT - 1);

  logic [2:0] cnt_q, cnt_d;

  // Next count: reload on a new read, otherwise count down and park at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = LOAD_VAL;
    end else if (cnt_q != 3'd0) begin
      cnt_d = cnt_q - 3'd1;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last = (cnt_q == 3'd0);

endmodule

// File: rtl/rc4_ksa_param.sv
// RC4 key-scheduling engine driving a single-port S-box RAM.
// Optional feature macro: RC4_KSA_FILL_EN -- when defined, the S-box is first
// filled with the identity permutation; otherwise the caller must preload it.
module rc4_ksa_param
  import rc4_pkg::*;
#(
  parameter int KEY_BYTES  = 3,
  parameter int MEM_RD_LAT = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [8*KEY_BYTES-1:0] key,
  input  logic [7:0]             mem_q,
  output logic                   busy,
  output logic                   done,
  output logic [7:0]             mem_address,
  output logic [7:0]             mem_data,
  output logic                   mem_wren
);

  localparam logic [4:0] KEY_LAST = 5'(KEY_BYTES - 1);

  state_t                 state_q, state_d;
  logic [7:0]             i_q, i_d;
  logic [7:0]             j_q, j_d;
  logic [4:0]             k_q, k_d;
  logic [8*KEY_BYTES-1:0] key_q, key_d;
  logic [7:0]             data_i_q, data_i_d;
  logic [7:0]             data_j_q, data_j_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [7:0]             mem_address_q, mem_address_d;
  logic [7:0]             mem_data_q, mem_data_d;
  logic                   mem_wren_q, mem_wren_d;

  logic [MAX_KEY_BYTES*BYTE_W-1:0] key_ext;
  logic                            rd_load;
  logic                            rd_last;

  // One wait counter serves both the S[i] and the S[j] reads.
  assign rd_load = (state_q == ST_RD_I) || (state_q == ST_RD_J);

  rc4_rd_wait #(
    .MEM_RD_LAT (MEM_RD_LAT)
  ) u_rd_wait (
    .clk   (clk),
    .reset (reset),
    .load  (rd_load),
    .last  (rd_last)
  );

  // Zero-extend the latched key so the package helper can index it.
  always_comb begin
    key_ext                  = '0;
    key_ext[8*KEY_BYTES-1:0] = key_q;
  end

  // Next-state and datapath update; outputs are then derived from the next
  // state so they are registered and line up with the state they belong to.
  always_comb begin
    // NOTE: every target gets a default up front so no path leaves one unassigned and infers a latch.
    state_d  = state_q;
    i_d      = i_q;
    j_d      = j_q;
    k_d      = k_q;
    key_d    = key_q;
    data_i_d = data_i_q;
    data_j_d = data_j_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          key_d = key;
          i_d   = 8'd0;
          j_d   = 8'd0;
          k_d   = 5'd0;
`ifdef RC4_KSA_FILL_EN
          state_d = ST_FILL;
`else
          state_d = ST_RD_I;
`endif
        end
      end
`ifdef RC4_KSA_FILL_EN
      ST_FILL: begin
        i_d = i_q + 8'd1;
        if (i_q == 8'hFF) begin
          state_d = ST_RD_I;
        end
      end
`endif
      ST_RD_I: state_d = ST_WAIT_I;
      ST_WAIT_I: begin
        if (rd_last) begin
          data_i_d = mem_q;
          state_d  = ST_CALC_J;
        end
      end
      ST_CALC_J: begin
        j_d     = j_q + data_i_q + key_byte(key_ext, KEY_BYTES, k_q);
        state_d = ST_RD_J;
      end
      ST_RD_J: state_d = ST_WAIT_J;
      ST_WAIT_J: begin
        if (rd_last) begin
          data_j_d = mem_q;
          state_d  = ST_WR_J;
        end
      end
      ST_WR_J: state_d = ST_WR_I;
      ST_WR_I: state_d = ST_NEXT;
      ST_NEXT: begin
        if (i_q == 8'hFF) begin
          state_d = ST_DONE;
        end else begin
          i_d     = i_q + 8'd1;
          k_d     = (k_q == KEY_LAST) ? 5'd0 : k_q + 5'd1;
          state_d = ST_RD_I;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // RAM port values for the state being entered; address and data hold
    // through the wait states, write enable is only raised for writes.
    mem_address_d = mem_address_q;
    mem_data_d    = mem_data_q;
    mem_wren_d    = 1'b0;
    case (state_d)
      ST_FILL: begin
        mem_address_d = i_d;
        mem_data_d    = i_d;
        mem_wren_d    = 1'b1;
      end
      ST_RD_I: mem_address_d = i_d;
      ST_RD_J: mem_address_d = j_d;
      ST_WR_J: begin
        mem_address_d = j_d;
        mem_data_d    = data_i_d;
        mem_wren_d    = 1'b1;
      end
      ST_WR_I: begin
        mem_address_d = i_d;
        mem_data_d    = data_j_d;
        mem_wren_d    = 1'b1;
      end
      default: ;
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // State and output registers; reset takes priority over a concurrent start.
  // The S-box lives in external RAM and is deliberately left as-is on reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q       <= ST_IDLE;
      i_q           <= '0;
      j_q           <= '0;
      k_q           <= '0;
      key_q         <= '0;
      data_i_q      <= '0;
      data_j_q      <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      mem_address_q <= '0;
      mem_data_q    <= '0;
      mem_wren_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      i_q           <= i_d;
      j_q           <= j_d;
      k_q           <= k_d;
      key_q         <= key_d;
      data_i_q      <= data_i_d;
      data_j_q      <= data_j_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      mem_address_q <= mem_address_d;
      mem_data_q    <= mem_data_d;
      mem_wren_q    <= mem_wren_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign mem_address = mem_address_q;
  assign mem_data    = mem_data_q;
  assign mem_wren    = mem_wren_q;

endmodule

// File: tb/tb_rc4_ksa_param.sv
// Bench for rc4_ksa_param: two instances (3-byte key / 3-cycle RAM and
// 5-byte key / 1-cycle RAM), each with its own behavioural S-box RAM.
// Expected S-boxes and latencies come from a reference KSA in the bench.
module tb_rc4_ksa_param;

  localparam int KB_A  = 3;
  localparam int LAT_A = 3;
  localparam int KB_B  = 5;
  localparam int LAT_B = 1;
`ifdef RC4_KSA_FILL_EN
  localparam bit FILL = 1'b1;
`else
  localparam bit FILL = 1'b0;
`endif
  localparam int FILL_CYC = FILL ? 256 : 0;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start_a = 1'b0, start_b = 1'b0;
  logic [8*KB_A-1:0] key_a = '0;
  logic [8*KB_B-1:0] key_b = '0;
  logic [7:0] mem_q_a, mem_q_b;
  logic busy_a, done_a, wren_a, busy_b, done_b, wren_b;
  logic [7:0] addr_a, data_a, addr_b, data_b;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0] ram_a [256];
  logic [7:0] ram_b [256];
  logic [7:0] pre   [256];
  logic       preload_a = 1'b0, preload_b = 1'b0;
  logic [7:0] pipe_a [LAT_A];
  logic [7:0] pipe_b [LAT_B];
  int         wcnt_a = 0;
  logic [7:0] wl_addr [2];
  logic [7:0] wl_data [2];

  logic [7:0] exp_q [$];
  int         lat_q [$];

  rc4_ksa_param #(.KEY_BYTES(KB_A), .MEM_RD_LAT(LAT_A)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .key(key_a), .mem_q(mem_q_a),
    .busy(busy_a), .done(done_a), .mem_address(addr_a), .mem_data(data_a), .mem_wren(wren_a)
  );

  rc4_ksa_param #(.KEY_BYTES(KB_B), .MEM_RD_LAT(LAT_B)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .key(key_b), .mem_q(mem_q_b),
    .busy(busy_b), .done(done_b), .mem_address(addr_b), .mem_data(data_b), .mem_wren(wren_b)
  );

  always #5 clk = ~clk;

  // Free-running cycle counter used for latency measurement.
  always @(posedge clk) cyc <= cyc + 1;

  // RAM A: bulk preload, synchronous write, MEM_RD_LAT-deep read pipeline,
  // plus a log of the first two swap-loop writes.
  always @(posedge clk) begin
    if (preload_a) begin
      for (int x = 0; x < 256; x++) ram_a[x] <= pre[x];
      wcnt_a <= 0;
    end else if (wren_a) begin
      ram_a[addr_a] <= data_a;
      if (wcnt_a == FILL_CYC)     begin wl_addr[0] <= addr_a; wl_data[0] <= data_a; end
      if (wcnt_a == FILL_CYC + 1) begin wl_addr[1] <= addr_a; wl_data[1] <= data_a; end
      wcnt_a <= wcnt_a + 1;
    end
    pipe_a[0] <= addr_a;
    for (int x = 1; x < LAT_A; x++) pipe_a[x] <= pipe_a[x-1];
  end
  assign mem_q_a = ram_a[pipe_a[LAT_A-1]];

  // RAM B: same model with its own latency.
  always @(posedge clk) begin
    if (preload_b) begin
      for (int x = 0; x < 256; x++) ram_b[x] <= pre[x];
    end else if (wren_b) begin
      ram_b[addr_b] <= data_b;
    end
    pipe_b[0] <= addr_b;
    for (int x = 1; x < LAT_B; x++) pipe_b[x] <= pipe_b[x-1];
  end
  assign mem_q_b = ram_b[pipe_b[LAT_B-1]];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Load the selected RAM: random garbage when the engine fills it itself,
  // identity otherwise.
  task automatic preload(input bit sel);
    @(negedge clk);
    for (int x = 0; x < 256; x++) pre[x] = FILL ? 8'($urandom) : 8'(x);
    if (sel) preload_b = 1'b1; else preload_a = 1'b1;
    @(negedge clk);
    preload_a = 1'b0;
    preload_b = 1'b0;
  endtask

  // Reference KSA over the starting S-box; pushes expected bytes and latency.
  task automatic push_ref(input logic [39:0] key, input int nb, input int lat);
    logic [7:0] s [256];
    logic [7:0] j, t, kb;
    for (int x = 0; x < 256; x++) s[x] = FILL ? 8'(x) : pre[x];
    j = 8'd0;
    for (int i = 0; i < 256; i++) begin
      kb   = key[8*(nb-1-(i % nb)) +: 8];
      j    = j + s[i] + kb;
      t    = s[i];
      s[i] = s[j];
      s[j] = t;
    end
    for (int x = 0; x < 256; x++) exp_q.push_back(s[x]);
    lat_q.push_back(1 + FILL_CYC + 256 * (2 * lat + 6));
  endtask

  // One complete key schedule on instance sel, optionally with a stray start
  // pulse 100 cycles in; checks timing, handshake and the final S-box.
  task automatic run(input bit sel, input logic [39:0] key, input bit extra);
    int nb, lat, c_s, c_d, n, dones, budget, exp_l;
    bit got, d;
    bit seen [256];
    int distinct;
    nb  = sel ? KB_B : KB_A;
    lat = sel ? LAT_B : LAT_A;
    preload(sel);
    push_ref(key, nb, lat);
    budget = 1 + FILL_CYC + 256 * (2 * lat + 6) + 50;

    @(negedge clk);
    if (sel) begin key_b = key[8*KB_B-1:0]; start_b = 1'b1; end
    else     begin key_a = key[8*KB_A-1:0]; start_a = 1'b1; end
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    key_a   = ~key_a;
    key_b   = ~key_b;
    c_s = cyc;
    check("busy_after_start", {31'd0, sel ? busy_b : busy_a}, 32'd1);

    n = 0; got = 0; dones = 0; c_d = 0;
    while (n < budget && !got) begin
      @(negedge clk);
      n++;
      if (sel) start_b = extra && (n == 100); else start_a = extra && (n == 100);
      d = sel ? done_b : done_a;
      if (d) begin got = 1; dones++; c_d = cyc; end
    end
    start_a = 1'b0;
    start_b = 1'b0;
    check("done_seen", {31'd0, got}, 32'd1);

    for (int x = 0; x < 6; x++) begin
      @(negedge clk);
      if (sel ? done_b : done_a) dones++;
    end
    check("done_pulses", 32'(dones), 32'd1);
    check("busy_idle", {31'd0, sel ? busy_b : busy_a}, 32'd0);

    exp_l = lat_q.pop_front();
    check("latency", 32'(c_d - c_s + 1), 32'(exp_l));

    distinct = 0;
    for (int x = 0; x < 256; x++) seen[x] = 1'b0;
    for (int x = 0; x < 256; x++) begin
      logic [7:0] v;
      v = sel ? ram_b[x] : ram_a[x];
      check($sformatf("sbox[%0d]", x), {24'd0, v}, {24'd0, exp_q.pop_front()});
      if (!seen[v]) begin seen[v] = 1'b1; distinct++; end
    end
    check("permutation", 32'(distinct), 32'd256);
  endtask

  initial begin
    for (int x = 0; x < 256; x++) pre[x] = 8'(x);
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy_a}, 32'd0);
    check("rst_done", {31'd0, done_a}, 32'd0);
    check("rst_wren", {31'd0, wren_a}, 32'd0);
    check("rst_addr", {24'd0, addr_a}, 32'd0);
    check("rst_data", {24'd0, data_a}, 32'd0);
    check("rst_busy_b", {31'd0, busy_b}, 32'd0);
    reset = 1'b0;

    // All-zero key: first iteration has i == j == 0.
    run(1'b0, 40'h0, 1'b0);
    check("ieqj_addr0", {24'd0, wl_addr[0]}, 32'd0);
    check("ieqj_data0", {24'd0, wl_data[0]}, 32'd0);
    check("ieqj_addr1", {24'd0, wl_addr[1]}, 32'd0);
    check("ieqj_data1", {24'd0, wl_data[1]}, 32'd0);

    // Five-byte key on the single-cycle-latency instance.
    run(1'b1, 40'h0102030405, 1'b0);

    // Stray start while busy must not disturb key or timing.
    run(1'b0, 40'h4B6579, 1'b1);

    // Reset together with start in the middle of a swap loop.
    preload(1'b0);
    @(negedge clk);
    key_a   = 24'hABCDEF;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (500) @(negedge clk);
    reset   = 1'b1;
    start_a = 1'b1;
    @(negedge clk);
    reset   = 1'b0;
    start_a = 1'b0;
    check("midrst_busy", {31'd0, busy_a}, 32'd0);
    check("midrst_wren", {31'd0, wren_a}, 32'd0);
    check("midrst_done", {31'd0, done_a}, 32'd0);
    check("midrst_addr", {24'd0, addr_a}, 32'd0);
    @(negedge clk);
    check("midrst_stays_idle", {31'd0, busy_a}, 32'd0);

    // Fresh start after the abort.
    run(1'b0, 40'h123456, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
